// File: rtl/sha1_apb_sequencer.sv
// APB master that streams one 16-word block into the SHA-1 peripheral, starts
// compression, waits with a timeout and reads H0..H4 back as a 160-bit digest.
module sha1_apb_sequencer #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         PCLK_IN,
    input  logic         PRESET_IN,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [31:0]  msg_data,
    input  logic         msg_first,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [159:0] digest_data,
    output logic         busy,
    output logic         error,
    output logic         PRESETn_OUT,
    output logic         PSEL_OUT,
    output logic         PENABLE_OUT,
    output logic         PWRITE_OUT,
    output logic [4:0]   PADDR_OUT,
    output logic [31:0]  PWDATA_OUT,
    input  logic         PREADY_IN,
    input  logic [31:0]  PRDATA_IN
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, CORE_RST, WRITE, START, WAIT, READ, DONE, ERR
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    wcnt, wcnt_nx;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic [2:0]    rcnt, rcnt_nx;
    logic          error_nx;
    logic          psel_nx, penable_nx, pwrite_nx;
    logic [4:0]    paddr_nx;
    logic [31:0]   pwdata_nx;
    logic          capture;

    assign msg_ready    = (state == WRITE);
    assign digest_valid = (state == DONE);
    assign busy         = (state != IDLE);

    always_comb begin
        state_nx   = state;
        wcnt_nx    = wcnt;
        tcnt_nx    = tcnt;
        rcnt_nx    = rcnt;
        error_nx   = error;
        psel_nx    = 1'b0;
        penable_nx = 1'b0;
        pwrite_nx  = 1'b0;
        paddr_nx   = PADDR_OUT;
        pwdata_nx  = PWDATA_OUT;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (msg_valid) begin
                    state_nx = msg_first ? CORE_RST : WRITE;
                    error_nx = 1'b0;
                end
            end
            CORE_RST: state_nx = WRITE;
            WRITE: begin
                if (msg_valid) begin
                    psel_nx   = 1'b1;
                    pwrite_nx = 1'b1;
                    paddr_nx  = {1'b0, wcnt};
                    pwdata_nx = msg_data;
                    wcnt_nx   = wcnt + 4'd1;
                    if (wcnt == 4'd15) state_nx = START;
                end
            end
            START: begin
                psel_nx    = 1'b1;
                penable_nx = 1'b1;
                paddr_nx   = 5'd0;
                tcnt_nx    = '0;
                state_nx   = WAIT;
            end
            WAIT: begin
                // The core still reports ready during the enable cycle, so the
                // first WAIT cycle (tcnt==0) cannot signal completion.
                if (tcnt != '0 && PREADY_IN) begin
                    paddr_nx = 5'd16;
                    rcnt_nx  = 3'd0;
                    state_nx = READ;
                end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    error_nx = 1'b1;
                    state_nx = ERR;
                end else begin
                    psel_nx = 1'b1;
                    tcnt_nx = tcnt + TW'(1);
                end
            end
            READ: begin
                // Read data lags the address by one cycle: capture from rcnt 1..5.
                capture = (rcnt != 3'd0);
                if (rcnt < 3'd4) paddr_nx = 5'd17 + {2'b00, rcnt};
                if (rcnt == 3'd5) state_nx = DONE;
                else              rcnt_nx  = rcnt + 3'd1;
            end
            DONE: if (digest_ready) state_nx = IDLE;
            ERR:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge PCLK_IN or posedge PRESET_IN) begin
        if (PRESET_IN) begin
            state       <= IDLE;
            wcnt        <= '0;
            tcnt        <= '0;
            rcnt        <= '0;
            error       <= 1'b0;
            PRESETn_OUT <= 1'b0;
            PSEL_OUT    <= 1'b0;
            PENABLE_OUT <= 1'b0;
            PWRITE_OUT  <= 1'b0;
            PADDR_OUT   <= '0;
            PWDATA_OUT  <= '0;
            digest_data <= '0;
        end else begin
            state       <= state_nx;
            wcnt        <= wcnt_nx;
            tcnt        <= tcnt_nx;
            rcnt        <= rcnt_nx;
            error       <= error_nx;
            PRESETn_OUT <= !(state_nx == CORE_RST || state_nx == ERR);
            PSEL_OUT    <= psel_nx;
            PENABLE_OUT <= penable_nx;
            PWRITE_OUT  <= pwrite_nx;
            PADDR_OUT   <= paddr_nx;
            PWDATA_OUT  <= pwdata_nx;
            if (capture) digest_data <= {digest_data[127:0], PRDATA_IN};
        end
    end
endmodule

// File: tb/tb_sha1_apb_sequencer.sv
// Scoreboard bench for sha1_apb_sequencer with a behavioural SHA-1 APB core and
// a second instance (TIMEOUT_CYCLES=20) attached to a core that never finishes.
module tb_sha1_apb_sequencer;
    localparam logic [159:0] ABC_DG = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] TWO_DG = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;
    localparam logic [31:0] ABC_BLK [16] = '{
        32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018};
    localparam logic [31:0] TWO_BLK1 [16] = '{
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [31:0] TWO_BLK2 [16] = '{
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         m_valid = 1'b0, m_first = 1'b0, m_ready;
    logic [31:0]  m_data = 32'h0;
    logic         d_valid, d_ready = 1'b1;
    logic [159:0] d_data;
    logic         busy, err, prstn, psel, pen, pwr, pready;
    logic [4:0]   paddr;
    logic [31:0]  pwdata, prdata;

    logic         t_valid = 1'b0, t_first = 1'b0, t_ready;
    logic [31:0]  t_data = 32'h0;
    logic         t_dvalid, t_busy, t_err, t_prstn, t_psel, t_pen, t_pwr;
    logic [159:0] t_ddata;
    logic [4:0]   t_paddr;
    logic [31:0]  t_pwdata;

    sha1_apb_sequencer dut (
        .PCLK_IN(clk), .PRESET_IN(rst),
        .msg_valid(m_valid), .msg_ready(m_ready), .msg_data(m_data), .msg_first(m_first),
        .digest_valid(d_valid), .digest_ready(d_ready), .digest_data(d_data),
        .busy(busy), .error(err), .PRESETn_OUT(prstn),
        .PSEL_OUT(psel), .PENABLE_OUT(pen), .PWRITE_OUT(pwr),
        .PADDR_OUT(paddr), .PWDATA_OUT(pwdata),
        .PREADY_IN(pready), .PRDATA_IN(prdata));

    sha1_apb_sequencer #(.TIMEOUT_CYCLES(20)) dut_to (
        .PCLK_IN(clk), .PRESET_IN(rst),
        .msg_valid(t_valid), .msg_ready(t_ready), .msg_data(t_data), .msg_first(t_first),
        .digest_valid(t_dvalid), .digest_ready(1'b1), .digest_data(t_ddata),
        .busy(t_busy), .error(t_err), .PRESETn_OUT(t_prstn),
        .PSEL_OUT(t_psel), .PENABLE_OUT(t_pen), .PWRITE_OUT(t_pwr),
        .PADDR_OUT(t_paddr), .PWDATA_OUT(t_pwdata),
        .PREADY_IN(1'b0), .PRDATA_IN(32'h0));

    // Behavioural SHA-1 APB peripheral: one round per setup cycle while busy.
    logic [31:0] ch [5];
    logic [31:0] cw [16];
    logic [31:0] ca, cb, cc, cd, ce;
    logic        c_busy;
    logic [6:0]  c_rnd;
    logic [3:0]  t4;
    logic [31:0] w_mix, w_t, f_t, k_t, tmp_t;

    assign pready = !c_busy;

    always_comb begin
        t4    = c_rnd[3:0];
        w_mix = cw[4'(t4 + 4'd13)] ^ cw[4'(t4 + 4'd8)] ^ cw[4'(t4 + 4'd2)] ^ cw[t4];
        w_t   = (c_rnd < 7'd16) ? cw[t4] : {w_mix[30:0], w_mix[31]};
        if (c_rnd < 7'd20) begin
            f_t = (cb & cc) | (~cb & cd);          k_t = 32'h5A827999;
        end else if (c_rnd < 7'd40) begin
            f_t = cb ^ cc ^ cd;                    k_t = 32'h6ED9EBA1;
        end else if (c_rnd < 7'd60) begin
            f_t = (cb & cc) | (cb & cd) | (cc & cd); k_t = 32'h8F1BBCDC;
        end else begin
            f_t = cb ^ cc ^ cd;                    k_t = 32'hCA62C1D6;
        end
        tmp_t = {ca[26:0], ca[31:27]} + f_t + ce + k_t + w_t;
    end

    always_ff @(posedge clk) begin
        if (!prstn) begin
            ch[0] <= 32'h67452301; ch[1] <= 32'hEFCDAB89; ch[2] <= 32'h98BADCFE;
            ch[3] <= 32'h10325476; ch[4] <= 32'hC3D2E1F0;
            c_busy <= 1'b0; c_rnd <= 7'd0; prdata <= 32'h0;
        end else begin
            prdata <= (paddr >= 5'd16 && paddr <= 5'd20) ? ch[paddr[2:0]] : 32'h0;
            if (psel && !pen && pwr && pready) cw[paddr[3:0]] <= pwdata;
            if (psel && pen && !c_busy) begin
                c_busy <= 1'b1; c_rnd <= 7'd0;
                ca <= ch[0]; cb <= ch[1]; cc <= ch[2]; cd <= ch[3]; ce <= ch[4];
            end else if (psel && !pen && c_busy) begin
                ce <= cd; cd <= cc; cc <= {cb[1:0], cb[31:2]}; cb <= ca; ca <= tmp_t;
                if (c_rnd >= 7'd16) cw[t4] <= w_t;
                c_rnd <= c_rnd + 7'd1;
                if (c_rnd == 7'd79) begin
                    ch[0] <= ch[0] + tmp_t; ch[1] <= ch[1] + ca;
                    ch[2] <= ch[2] + {cb[1:0], cb[31:2]};
                    ch[3] <= ch[3] + cc;    ch[4] <= ch[4] + cd;
                    c_busy <= 1'b0;
                end
            end
        end
    end

    typedef struct { logic [4:0] addr; logic [31:0] data; } wr_t;
    typedef struct { bit check_en; logic [159:0] val; } dg_t;
    wr_t wq[$];
    dg_t dq[$];
    logic [31:0] blk [16];
    int n_checks = 0, n_pass = 0;
    int en_cnt = 0, rst_cnt = 0;

    task automatic check(input string nm, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    endtask

    // Write and digest monitors pop the expectations queued by the stimulus.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (pen) en_cnt++;
            if (!prstn) rst_cnt++;
            if (psel && !pen && pwr) begin
                if (wq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write addr=%0d data=%0h", paddr, pwdata);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_addr", 160'(paddr), 160'(e.addr));
                    check("wr_data", 160'(pwdata), 160'(e.data));
                end
            end
            if (d_valid && d_ready) begin
                if (dq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_digest got=%0h", d_data);
                end else begin
                    dg_t g;
                    g = dq.pop_front();
                    if (g.check_en) check("digest", d_data, g.val);
                end
            end
        end
    end

    task automatic send_block(input bit first, input bit gaps, input int nwords);
        for (int i = 0; i < nwords; i++) begin
            bit hs;
            int guard;
            hs = 1'b0;
            guard = 0;
            m_valid = 1'b1; m_data = blk[i]; m_first = first && (i == 0);
            while (!hs && guard < 300) begin
                @(negedge clk); hs = m_ready;
                @(posedge clk); #1; guard++;
            end
            if (!hs) begin
                n_checks++;
                $display("FAIL msg_handshake word=%0d not accepted within bound", i);
            end else wq.push_back('{addr: 5'(i), data: blk[i]});
            if (gaps) begin m_valid = 1'b0; @(posedge clk); #1; end
        end
        m_valid = 1'b0; m_first = 1'b0;
    endtask

    task automatic wait_digest(input string nm);
        int guard;
        guard = 0;
        while (dq.size() != 0 && guard < 600) begin @(negedge clk); guard++; end
        if (dq.size() != 0) begin
            n_checks++;
            $display("FAIL %s digest not produced within bound, pending=%0d", nm, dq.size());
            dq.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc, guard;
        bit dv_seen;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 160'({m_ready, d_valid, busy, err, prstn, psel, pen, pwr, paddr, pwdata}), 160'h0);
        check("reset_digest", d_data, 160'h0);
        @(negedge clk); #1 rst = 1'b0;
        #1 check("presetn_before_edge", 160'(prstn), 160'h0);
        @(posedge clk); #1 check("presetn_after_edge", 160'(prstn), 160'h1);

        // Asynchronous reset in the middle of WRITE.
        blk = ABC_BLK;
        send_block(1'b1, 1'b0, 5);
        #1 rst = 1'b1;
        wq.delete();
        #1 check("midblock_reset_outputs",
                 160'({m_ready, d_valid, busy, err, prstn, psel, pen, pwr, paddr, pwdata}), 160'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst = 1'b0;
        #1 check("mid_presetn_held", 160'(prstn), 160'h0);
        @(posedge clk); #1 check("mid_presetn_release", 160'(prstn), 160'h1);

        // "abc" single block.
        en_cnt = 0; rst_cnt = 0;
        dq.push_back('{check_en: 1'b1, val: ABC_DG});
        send_block(1'b1, 1'b0, 16);
        wait_digest("abc");
        check("abc_core_resets", 160'(rst_cnt), 160'd1);
        check("abc_enable_cycles", 160'(en_cnt), 160'd1);
        check("abc_writes_drained", 160'(wq.size()), 160'd0);

        // Backpressure on both streams.
        en_cnt = 0; rst_cnt = 0;
        d_ready = 1'b0;
        dq.push_back('{check_en: 1'b1, val: ABC_DG});
        send_block(1'b1, 1'b1, 16);
        guard = 0;
        while (!d_valid && guard < 600) begin @(negedge clk); guard++; end
        m_valid = 1'b1; m_first = 1'b1; m_data = 32'h0;
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {d_valid, m_ready, d_data}, {1'b1, 1'b0, ABC_DG});
            @(negedge clk);
        end
        @(posedge clk); #1;
        m_valid = 1'b0; m_first = 1'b0; d_ready = 1'b1;
        wait_digest("backpressure");
        check("bp_enable_cycles", 160'(en_cnt), 160'd1);
        check("bp_writes_drained", 160'(wq.size()), 160'd0);

        // Two-block message.
        en_cnt = 0; rst_cnt = 0;
        blk = TWO_BLK1;
        dq.push_back('{check_en: 1'b0, val: 160'h0});
        send_block(1'b1, 1'b0, 16);
        wait_digest("two_block1");
        check("two_b1_core_resets", 160'(rst_cnt), 160'd1);
        check("two_b1_enable_cycles", 160'(en_cnt), 160'd1);
        en_cnt = 0; rst_cnt = 0;
        blk = TWO_BLK2;
        dq.push_back('{check_en: 1'b1, val: TWO_DG});
        send_block(1'b0, 1'b0, 16);
        wait_digest("two_block2");
        check("two_b2_core_resets", 160'(rst_cnt), 160'd0);
        check("two_b2_enable_cycles", 160'(en_cnt), 160'd1);

        // Timeout against a core that never completes.
        for (int i = 0; i < 16; i++) begin
            bit hs;
            int g2;
            hs = 1'b0;
            g2 = 0;
            t_valid = 1'b1; t_data = 32'(i); t_first = (i == 0);
            while (!hs && g2 < 300) begin
                @(negedge clk); hs = t_ready;
                @(posedge clk); #1; g2++;
            end
            if (!hs) begin
                n_checks++;
                $display("FAIL to_handshake word=%0d not accepted within bound", i);
            end
        end
        t_valid = 1'b0; t_first = 1'b0;
        wc = 0; dv_seen = 1'b0; guard = 0;
        while (!t_err && guard < 200) begin
            @(negedge clk); guard++;
            if (t_dvalid) dv_seen = 1'b1;
            if (t_psel && !t_pwr) wc++;
        end
        check("to_wait_cycles", 160'(wc), 160'd20);
        check("to_err_cycle", 160'({t_err, t_prstn, t_dvalid}), 160'b100);
        check("to_no_digest", 160'(dv_seen), 160'd0);
        @(negedge clk);
        check("to_idle_sticky", 160'({t_err, t_prstn, t_busy}), 160'b110);
        t_valid = 1'b1; t_first = 1'b1; t_data = 32'h0;
        @(negedge clk);
        check("to_err_cleared", 160'({t_err, t_prstn, t_busy}), 160'b001);
        t_valid = 1'b0; t_first = 1'b0;

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sha1_apb_sequencer.md
# sha1_apb_sequencer

APB master that sequences the SHA-1 APB peripheral for one requester. It accepts a 16-word message block on a valid/ready stream and, for the first block of a message, resets the core. It then writes the block into the core's message registers, starts compression and waits for completion with a timeout. Finally it reads H0..H4 back and presents the 160-bit intermediate digest on a valid/ready output.

## Interface
- TIMEOUT_CYCLES, 1023: maximum WAIT cycles before abort; wait counter width is $clog2(TIMEOUT_CYCLES+1).
- PCLK_IN  in  1  clock; all logic on rising edge.
- PRESET_IN  in  1  reset, asynchronous, active-high.
- msg_valid  in  1  block word valid; msg_data/msg_first stable while valid.
- msg_ready  out  1  word accepted on msg_valid && msg_ready.
- msg_data  in  32  message word, big-endian SHA-1 word order.
- msg_first  in  1  with word 0 only: block starts a new message.
- digest_valid  out  1  digest available; held until accepted.
- digest_ready  in  1  consumer accept.
- digest_data  out  160  {H0,H1,H2,H3,H4}, H0 in [159:128].
- busy  out  1  state != IDLE.
- error  out  1  sticky timeout flag.
- PRESETn_OUT  out  1  core reset, active-low, registered.
- PSEL_OUT, PENABLE_OUT, PWRITE_OUT  out  1 each  APB controls, registered.
- PADDR_OUT  out  5  APB address, registered.
- PWDATA_OUT  out  32  APB write data, registered.
- PREADY_IN  in  1  core ready.
- PRDATA_IN  in  32  core read data; valid one cycle after PADDR_OUT is presented.

## Operation
- **Reset values** (asynchronous, while PRESET_IN is high):
  - state=IDLE; msg_ready=0, digest_valid=0, digest_data=0, busy=0, error=0.
  - PRESETn_OUT=0, PSEL/PENABLE/PWRITE=0, PADDR=0, PWDATA=0; counters=0.
  - PRESETn_OUT rises at the first edge after release.
- **No combinational paths** from msg_* or PREADY_IN to any APB output.
- **Core bus rules:**
  - The core captures a write on setup cycles only: PSEL=1, PENABLE=0, PWRITE=1, while PREADY_IN=1.
  - One PSEL=1, PENABLE=1 cycle starts compression.
  - Compression advances only while PSEL=1 and PENABLE=0.
  - Reads need no PSEL; the sequencer drives PSEL=0 during reads.
- **IDLE:**
  - msg_ready=0.
  - On msg_valid: go to CORE_RST if msg_first, else to WRITE.
  - error clears on this transition.
- **CORE_RST:** PRESETn_OUT=0 for exactly one cycle, then go to WRITE.
- **WRITE:**
  - msg_ready=1.
  - Each handshake registers PSEL=1, PENABLE=0, PWRITE=1, PADDR=wcnt, PWDATA=msg_data for the next cycle, and wcnt increments.
  - A cycle without a handshake registers PSEL=0.
  - On the 16th handshake wcnt wraps 15->0 and the state goes to START.
  - Stalls are allowed at any word; there is no upper bound.
- **START:**
  - The bus carries the write of word 15.
  - Registers PSEL=1, PENABLE=1, PWRITE=0, PADDR=0 for the next cycle; go to WAIT.
- **WAIT:**
  - Bus: the first cycle is the enable cycle; afterwards PSEL=1, PENABLE=0, PWRITE=0.
  - PREADY_IN is ignored in the first WAIT cycle, where the core still shows 1.
  - From the second cycle, PREADY_IN=1 means done: go to READ.
  - If the wait counter reaches TIMEOUT_CYCLES without done: go to ERR.
- **READ:**
  - PSEL=0; PADDR=16,17,18,19,20 on consecutive cycles.
  - PRDATA_IN is captured one cycle after each address, into H0..H4 in order.
  - Total 6 cycles, then go to DONE.
- **DONE:** digest_valid=1 and digest_data stable until digest_ready; then go to IDLE.
- **ERR:**
  - error=1 and PRESETn_OUT=0 for one cycle; no digest is produced; then go to IDLE.
  - The next block must carry msg_first, since the core hash has been lost.
- **Continuation blocks** (msg_first=0) skip CORE_RST; the core accumulates H.

## Timing
- Minimum block latency, first-word handshake to digest_valid: 1 (CORE_RST, first blocks only) + 16 WRITE + 1 START + WAIT + 6 READ.
- A new block is not accepted while digest_valid=1; the DONE->IDLE->accept path costs one IDLE cycle.
- PRESET_IN asserted mid-block aborts immediately:
  - the partial block is discarded;
  - the core is held in reset through PRESETn_OUT=0.
- Assertions a bench can check:
  - PADDR_OUT is never >15 with PWRITE_OUT=1.
  - PENABLE_OUT=1 occurs exactly once per block.

## Test plan
- **Reset.** Assert PRESET_IN asynchronously mid-WRITE.
  - Required: all outputs immediately at their reset values; PRESETn_OUT=0 until the first edge after release.
  - Required: next msg_first block proceeds normally.
- **"abc" single block.** Words 61626380, 00000000 x14, 00000018; msg_first=1.
  - Required: one PRESETn_OUT low cycle.
  - Required: 16 writes at addresses 0..15, one enable cycle.
  - Required: digest_data = a9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d.
- **Backpressure.** msg_valid toggled every other cycle; digest_ready held 0 for 10 cycles.
  - Required: writes appear only after handshakes, with addresses still 0..15.
  - Required: digest stable while not accepted; msg_ready=0 throughout.
- **Two-block message.** 56-byte message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" padded to two blocks; msg_first=1 then 0.
  - Required: no core reset before block 2.
  - Required: final digest = 84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1.
- **Timeout.** Core model holds PREADY_IN=0 forever, TIMEOUT_CYCLES=20.
  - Required: ERR after 20 WAIT cycles; error=1; one PRESETn_OUT low cycle; no digest_valid.
  - Required: error clears on the next block start.
